// File: rtl/md_if.sv
// Execute-stage to multiply/divide unit connection: issue controls, operands,
// and the unit's busy flag and HI/LO registers.
interface md_if;
  logic        E_start;
  logic [2:0]  E_md_op;
  logic [31:0] E_A;
  logic [31:0] E_B;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (
    output E_start, E_md_op, E_A, E_B,
    input  busy, HI, LO
  );

  modport slave (
    input  E_start, E_md_op, E_A, E_B,
    output busy, HI, LO
  );
endinterface

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// The result is computed at issue and parked in pending registers; it is
// committed to HI/LO only when the busy countdown expires, so HI/LO reads
// during the busy window still see the previous values.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic clk,
  input  logic reset,
  md_if.slave  md
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      hi_q, lo_q;
  logic [31:0]      pend_hi, pend_lo;
  logic             pend_wr;

  // Signed 32x32 -> 64 product.
  function automatic logic [63:0] mul_s(input logic signed [31:0] a,
                                        input logic signed [31:0] b);
    logic signed [63:0] ae, be, p;
    ae = a;
    be = b;
    p  = ae * be;
    return p;
  endfunction

  // Unsigned 32x32 -> 64 product.
  function automatic logic [63:0] mul_u(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ae, be;
    ae = {32'd0, a};
    be = {32'd0, b};
    return ae * be;
  endfunction

  // Signed divide returning {remainder, quotient}; the most-negative / -1
  // case is pinned explicitly so it never relies on wrapping behaviour.
  function automatic logic [63:0] div_s(input logic signed [31:0] a,
                                        input logic signed [31:0] b);
    logic signed [31:0] q, r;
    if (b == 32'sd0) begin
      return 64'd0;
    end else if (a == 32'sh8000_0000 && b == -32'sd1) begin
      return {32'd0, 32'h8000_0000};
    end else begin
      q = a / b;
      r = a % b;
      return {r, q};
    end
  endfunction

  // Unsigned divide returning {remainder, quotient}.
  function automatic logic [63:0] div_u(input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) begin
      return 64'd0;
    end else begin
      return {a % b, a / b};
    end
  endfunction

  // Issue/countdown FSM; owns HI/LO, the pending result and the busy counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      pend_wr <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (md.E_start) begin
            case (md.E_md_op)
              OP_MULT: begin
                {pend_hi, pend_lo} <= mul_s($signed(md.E_A), $signed(md.E_B));
                pend_wr <= 1'b1;
                cnt     <= MULT_LD;
                state   <= BUSY;
              end
              OP_MULTU: begin
                {pend_hi, pend_lo} <= mul_u(md.E_A, md.E_B);
                pend_wr <= 1'b1;
                cnt     <= MULT_LD;
                state   <= BUSY;
              end
              OP_DIV: begin
                {pend_hi, pend_lo} <= div_s($signed(md.E_A), $signed(md.E_B));
                pend_wr <= (md.E_B != 32'd0);
                cnt     <= DIV_LD;
                state   <= BUSY;
              end
              OP_DIVU: begin
                {pend_hi, pend_lo} <= div_u(md.E_A, md.E_B);
                pend_wr <= (md.E_B != 32'd0);
                cnt     <= DIV_LD;
                state   <= BUSY;
              end
              OP_MTHI: hi_q <= md.E_A;
              OP_MTLO: lo_q <= md.E_A;
              default: ;
            endcase
          end
        end
        BUSY: begin
          // New starts are ignored here, including on the completion edge.
          if (cnt <= CNT_ONE) begin
            if (pend_wr) begin
              hi_q <= pend_hi;
              lo_q <= pend_lo;
            end
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign md.busy = (state == BUSY);
  assign md.HI   = hi_q;
  assign md.LO   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Bench for md_unit: directed scenarios followed by randomized traffic, every
// cycle compared against a behavioural model of HI/LO and the busy window.
module tb_md_unit;

  localparam int MULT_CYCLES = 5;
  localparam int DIV_CYCLES  = 10;

  logic clk;
  logic reset;
  md_if bus ();

  md_unit #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES)) dut (
    .clk   (clk),
    .reset (reset),
    .md    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state: remaining busy cycles, committed and pending values.
  logic [31:0] m_hi, m_lo, m_ph, m_pl;
  bit          m_pwr;
  int          m_left;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_hi = 0; m_lo = 0; m_ph = 0; m_pl = 0; m_pwr = 0; m_left = 0;
  endtask

  // Advance the model by one rising edge using the inputs currently applied.
  task automatic model_edge();
    longint      sa, sb, q, r;
    logic [63:0] ua, ub, p;
    if (!reset) begin
      model_clear();
      return;
    end
    sa = $signed(bus.E_A);
    sb = $signed(bus.E_B);
    ua = {32'd0, bus.E_A};
    ub = {32'd0, bus.E_B};
    if (m_left > 0) begin
      m_left--;
      if (m_left == 0 && m_pwr) begin
        m_hi = m_ph;
        m_lo = m_pl;
      end
    end else if (bus.E_start) begin
      case (bus.E_md_op)
        3'd1: begin p = sa * sb; m_ph = p[63:32]; m_pl = p[31:0]; m_pwr = 1; m_left = MULT_CYCLES; end
        3'd2: begin p = ua * ub; m_ph = p[63:32]; m_pl = p[31:0]; m_pwr = 1; m_left = MULT_CYCLES; end
        3'd3: begin
          m_left = DIV_CYCLES;
          m_pwr  = (sb != 0);
          if (sb != 0) begin q = sa / sb; r = sa % sb; m_pl = q[31:0]; m_ph = r[31:0]; end
        end
        3'd4: begin
          m_left = DIV_CYCLES;
          m_pwr  = (ub != 0);
          if (ub != 0) begin p = ua / ub; m_pl = p[31:0]; p = ua % ub; m_ph = p[31:0]; end
        end
        3'd5: m_hi = bus.E_A;
        3'd6: m_lo = bus.E_A;
        default: ;
      endcase
    end
  endtask

  // One clock: update model, take the edge, compare outputs 1 time unit later.
  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
    chk("busy", {31'd0, bus.busy}, {31'd0, (m_left > 0)});
    chk("HI", bus.HI, m_hi);
    chk("LO", bus.LO, m_lo);
  endtask

  task automatic drive(input bit s, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.E_start = s;
    bus.E_md_op = op;
    bus.E_A     = a;
    bus.E_B     = b;
  endtask

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return $urandom_range(0, 20);
      4: return -$urandom_range(1, 20);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    reset = 1'b0;
    drive(0, 3'd0, 32'd0, 32'd0);
    model_clear();

    // Reset state, no clock yet.
    #3;
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_HI", bus.HI, 32'd0);
    chk("rst_LO", bus.LO, 32'd0);
    // A start while in reset must be ignored.
    drive(1, 3'd5, 32'hDEAD_BEEF, 32'd0);
    cycle();
    #7 reset = 1'b1;
    drive(0, 3'd0, 32'd0, 32'd0);
    cycle();

    // mult -2 * 3
    drive(1, 3'd1, 32'hFFFF_FFFE, 32'd3);
    cycle();
    drive(0, 3'd0, 32'd0, 32'd0);
    chk("mult_busy_start", {31'd0, bus.busy}, 32'd1);
    repeat (MULT_CYCLES - 1) cycle();
    chk("mult_busy_last", {31'd0, bus.busy}, 32'd1);
    cycle();
    chk("mult_busy_done", {31'd0, bus.busy}, 32'd0);
    chk("mult_HI", bus.HI, 32'hFFFF_FFFF);
    chk("mult_LO", bus.LO, 32'hFFFF_FFFA);

    // multu 0xFFFFFFFF * 2
    drive(1, 3'd2, 32'hFFFF_FFFF, 32'd2);
    cycle();
    drive(0, 3'd0, 32'd0, 32'd0);
    repeat (MULT_CYCLES) cycle();
    chk("multu_HI", bus.HI, 32'h0000_0001);
    chk("multu_LO", bus.LO, 32'hFFFF_FFFE);

    // div -7 / 2
    drive(1, 3'd3, 32'hFFFF_FFF9, 32'd2);
    cycle();
    drive(0, 3'd0, 32'd0, 32'd0);
    repeat (DIV_CYCLES - 1) cycle();
    chk("div_busy_last", {31'd0, bus.busy}, 32'd1);
    cycle();
    chk("div_LO", bus.LO, 32'hFFFF_FFFD);
    chk("div_HI", bus.HI, 32'hFFFF_FFFF);

    // divu 7 / 0 leaves HI/LO untouched
    drive(1, 3'd4, 32'd7, 32'd0);
    cycle();
    drive(0, 3'd0, 32'd0, 32'd0);
    repeat (DIV_CYCLES - 1) cycle();
    chk("divz_busy_last", {31'd0, bus.busy}, 32'd1);
    cycle();
    chk("divz_LO", bus.LO, 32'hFFFF_FFFD);
    chk("divz_HI", bus.HI, 32'hFFFF_FFFF);

    // Signed overflow divide
    drive(1, 3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    cycle();
    drive(0, 3'd0, 32'd0, 32'd0);
    repeat (DIV_CYCLES) cycle();
    chk("ovf_LO", bus.LO, 32'h8000_0000);
    chk("ovf_HI", bus.HI, 32'd0);

    // mthi then mtlo, no busy; ops 0 and 7 do nothing
    drive(1, 3'd5, 32'h1234_5678, 32'd0);
    cycle();
    chk("mthi_HI", bus.HI, 32'h1234_5678);
    chk("mthi_busy", {31'd0, bus.busy}, 32'd0);
    drive(1, 3'd6, 32'h9ABC_DEF0, 32'd0);
    cycle();
    chk("mtlo_LO", bus.LO, 32'h9ABC_DEF0);
    chk("mtlo_busy", {31'd0, bus.busy}, 32'd0);
    drive(1, 3'd0, 32'h1111_1111, 32'd1);
    cycle();
    drive(1, 3'd7, 32'h2222_2222, 32'd1);
    cycle();
    chk("nop_HI", bus.HI, 32'h1234_5678);
    chk("nop_LO", bus.LO, 32'h9ABC_DEF0);

    // div, mult issued at cycle 4 is ignored, reset pulsed mid-cycle
    drive(1, 3'd3, 32'd100, 32'd7);
    cycle();
    drive(0, 3'd0, 32'd0, 32'd0);
    repeat (3) cycle();
    drive(1, 3'd1, 32'd3, 32'd3);
    cycle();
    drive(0, 3'd0, 32'd0, 32'd0);
    #2 reset = 1'b0;
    #1;
    model_clear();
    chk("arst_busy", {31'd0, bus.busy}, 32'd0);
    chk("arst_HI", bus.HI, 32'd0);
    chk("arst_LO", bus.LO, 32'd0);
    #1 reset = 1'b1;
    repeat (DIV_CYCLES + 2) cycle();
    chk("post_rst_HI", bus.HI, 32'd0);
    chk("post_rst_LO", bus.LO, 32'd0);

    // Back-to-back: start on completion edge ignored, next edge accepted
    drive(1, 3'd1, 32'd6, 32'd7);
    cycle();
    drive(0, 3'd0, 32'd0, 32'd0);
    repeat (MULT_CYCLES - 1) cycle();
    drive(1, 3'd2, 32'd10, 32'd11);
    cycle();
    chk("b2b_gap_busy", {31'd0, bus.busy}, 32'd0);
    chk("b2b_first_LO", bus.LO, 32'd42);
    cycle();
    chk("b2b_second_busy", {31'd0, bus.busy}, 32'd1);
    drive(0, 3'd0, 32'd0, 32'd0);
    repeat (MULT_CYCLES) cycle();
    chk("b2b_second_LO", bus.LO, 32'd110);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      drive($urandom_range(0, 2) != 0, 3'($urandom_range(0, 7)), rnd_operand(), rnd_operand());
      cycle();
    end
    drive(0, 3'd0, 32'd0, 32'd0);
    repeat (DIV_CYCLES + 1) cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/md_unit.md
MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 Parameter MULT_CYCLES, default 5: busy duration in cycles for mult/multu.
REQ-002 Parameter DIV_CYCLES, default 10: busy duration in cycles for div/divu.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 E_start  input  1  Execute stage issues an md instruction this cycle.
REQ-006 E_md_op  input  3  operation code: 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo; 0 and 7 are no-ops.
REQ-007 E_A  input  32  rs operand, already forwarded.
REQ-008 E_B  input  32  rt operand, already forwarded.
REQ-009 busy  output  1  a multi-cycle operation is in progress; feeds the hazard unit.
REQ-010 HI  output  32  architectural HI register.
REQ-011 LO  output  32  architectural LO register.

Function
REQ-012 The FSM SHALL have two states, IDLE and BUSY; busy SHALL be 1 exactly in BUSY.
REQ-013 Start rule: in IDLE, E_start=1 with op 1-4 at edge T SHALL enter BUSY and load a down-counter with MULT_CYCLES (ops 1-2) or DIV_CYCLES (ops 3-4).
REQ-014 At that same edge T, the unit SHALL latch the result into internal pending HI/LO registers, computed from E_A and E_B.
REQ-015 mult: pending {HI,LO} = signed 32x32 product, 64 bits.
REQ-016 multu: pending {HI,LO} = unsigned 32x32 product, 64 bits.
REQ-017 div: LO = signed quotient, truncated toward zero; HI = remainder with the sign of the dividend.
REQ-018 divu: LO = unsigned quotient; HI = unsigned remainder.
REQ-019 Divide by zero (E_B=0, op 3 or 4): the unit SHALL go busy for DIV_CYCLES as usual and SHALL leave HI/LO unchanged at completion.
REQ-020 Signed overflow case 0x80000000 / 0xFFFFFFFF: LO SHALL be 0x80000000 and HI SHALL be 0.
REQ-021 Countdown: in BUSY, each edge SHALL decrement the counter.
REQ-022 Completion: at the edge where the counter goes 1->0, the unit SHALL copy the pending values into HI/LO and return to IDLE; busy SHALL therefore be high for exactly N cycles after T.
REQ-023 HI/LO SHALL hold their old values throughout BUSY; a read during BUSY returns the old values.
REQ-024 mthi/mtlo: in IDLE, E_start=1 with op 5 (or 6) SHALL write E_A into HI (or LO) at that edge, with no busy cycle.
REQ-025 Start while busy: E_start in BUSY SHALL be ignored; the counter and pending values SHALL be unaffected. The hazard unit stalls md instructions while busy or E_start is high.
REQ-026 E_start with op 0 or 7 SHALL have no effect.
REQ-027 Start coincident with completion: a start in the edge that ends BUSY SHALL be ignored, because the state is still BUSY at that edge.
REQ-028 Outputs: HI/LO SHALL be register outputs; busy SHALL be decoded from the state register only, with no combinational path from the inputs.

Reset
REQ-029 reset=0 SHALL immediately, without a clock, force IDLE, counter=0, busy=0, HI=0, LO=0 and pending HI/LO=0.
REQ-030 Reset asserted mid-operation SHALL discard the pending result; after reset deasserts, HI/LO SHALL remain 0 until the next write.
REQ-031 Release of reset SHALL take effect at the first rising edge after reset returns to 1; no start is accepted while reset=0.

Verification
REQ-032 mult with E_A=0xFFFFFFFE (-2), E_B=3 -> busy high for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-033 multu with E_A=0xFFFFFFFF, E_B=2 -> after 5 cycles HI=0x00000001, LO=0xFFFFFFFE.
REQ-034 div with E_A=-7 (0xFFFFFFF9), E_B=2 -> busy high for 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu with 7 and 0 -> HI/LO unchanged after 10 cycles.
REQ-035 mthi 0x12345678, then next cycle mtlo 0x9ABCDEF0 -> HI/LO updated on the respective edges, busy stays 0.
REQ-036 div started, then at cycle 4: E_start with mult, and reset pulsed low mid-cycle -> the mult is ignored; the reset clears busy, HI and LO asynchronously to 0; no completion write occurs afterwards.
REQ-037 Back-to-back: mult completes; a start on the completion edge is ignored; a start on the next edge is accepted -> busy low for at least 1 cycle between the two operations.
